// File: rtl/uart_tx_parity_framer_pkg.sv
// Shared UART definitions: frame FSM encoding, idle line level and parity modes.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } state_e;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_framer_if.sv
// Load/ready handshake and serial-line bundle for the UART TX framer.
// Optional UART_PARITY_INJECT_EN adds the inject_err request line.
interface uart_tx_parity_framer_if #(
   parameter int unsigned DATA_W = 8
) ();

   logic [DATA_W-1:0] tx_data;
   logic              load_data;
   logic              parity_en;
   logic              parity_odd;
`ifdef UART_PARITY_INJECT_EN
   logic              inject_err;
`endif
   logic              tx_ready;
   logic              tx_busy;
   logic              tx_out;
   logic              parity_bit;
   logic              tx_done;

`ifdef UART_PARITY_INJECT_EN
   modport master (
      output tx_data, load_data, parity_en, parity_odd, inject_err,
      input  tx_ready, tx_busy, tx_out, parity_bit, tx_done
   );
   modport slave (
      input  tx_data, load_data, parity_en, parity_odd, inject_err,
      output tx_ready, tx_busy, tx_out, parity_bit, tx_done
   );
`else
   modport master (
      output tx_data, load_data, parity_en, parity_odd,
      input  tx_ready, tx_busy, tx_out, parity_bit, tx_done
   );
   modport slave (
      input  tx_data, load_data, parity_en, parity_odd,
      output tx_ready, tx_busy, tx_out, parity_bit, tx_done
   );
`endif

endinterface

// File: rtl/uart_tx_parity_framer_parity_calc.sv
// Combinational even/odd parity of a data word; shared with the RX checker.
module uart_parity_calc
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_odd,
   output logic              o_parity
);

   assign o_parity = (^i_data) ^ (i_odd == PARITY_ODD);

endmodule

// File: rtl/uart_tx_parity_framer.sv
// UART TX framer: start, LSB-first data, optional parity, 1 or 2 stop bits.
// Optional UART_PARITY_INJECT_EN inverts the parity of a frame on request.
module uart_tx_parity_framer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1
) (
   input logic                    clk,
   input logic                    rst,
   uart_tx_parity_framer_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_W);

   state_e             r_state_q, r_state_d;
   logic [CNT_W-1:0]   r_cnt_q, r_cnt_d;
   logic [BIT_W-1:0]   r_bit_q, r_bit_d;
   logic [DATA_W-1:0]  r_shift_q, r_shift_d;
   logic               r_par_en_q, r_par_en_d;
   logic               r_par_val_q, r_par_val_d;
   logic               r_stop_q, r_stop_d;
   logic               r_tx_out_q, r_tx_out_d;
   logic               r_busy_q, r_busy_d;
   logic               r_done_q, r_done_d;
   logic               r_pbit_q, r_pbit_d;

   logic w_parity;
   logic w_inject;
   logic w_wrap;

`ifdef UART_PARITY_INJECT_EN
   assign w_inject = bus.inject_err;
`else
   assign w_inject = 1'b0;
`endif

   uart_parity_calc #(
      .DATA_W (DATA_W)
   ) u_parity (
      .i_data   (bus.tx_data),
      .i_odd    (bus.parity_odd),
      .o_parity (w_parity)
   );

   assign w_wrap = (r_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   always_comb begin
      r_state_d   = r_state_q;
      r_cnt_d     = r_cnt_q;
      r_bit_d     = r_bit_q;
      r_shift_d   = r_shift_q;
      r_par_en_d  = r_par_en_q;
      r_par_val_d = r_par_val_q;
      r_stop_d    = r_stop_q;
      r_tx_out_d  = r_tx_out_q;
      r_busy_d    = r_busy_q;
      r_pbit_d    = r_pbit_q;
      r_done_d    = 1'b0;

      if (r_state_q == StIdle) begin
         if (bus.load_data) begin
            r_state_d   = StStart;
            r_cnt_d     = '0;
            r_shift_d   = bus.tx_data;
            r_par_en_d  = bus.parity_en;
            r_par_val_d = w_parity ^ w_inject;
            r_pbit_d    = bus.parity_en & (w_parity ^ w_inject);
            r_busy_d    = 1'b1;
            r_tx_out_d  = 1'b0;
         end
      end else if (!w_wrap) begin
         r_cnt_d = r_cnt_q + CNT_W'(1);
      end else begin
         r_cnt_d = '0;
         unique case (r_state_q)
            StStart: begin
               r_state_d  = StData;
               r_bit_d    = '0;
               r_tx_out_d = r_shift_q[0];
            end
            StData: begin
               if (r_bit_q == BIT_W'(DATA_W - 1)) begin
                  r_state_d  = r_par_en_q ? StParity : StStop;
                  r_stop_d   = 1'b0;
                  r_tx_out_d = r_par_en_q ? r_par_val_q : IDLE_LEVEL;
               end else begin
                  r_bit_d    = r_bit_q + BIT_W'(1);
                  r_shift_d  = r_shift_q >> 1;
                  r_tx_out_d = r_shift_q[1];
               end
            end
            StParity: begin
               r_state_d  = StStop;
               r_stop_d   = 1'b0;
               r_tx_out_d = IDLE_LEVEL;
            end
            StStop: begin
               if (r_stop_q == 1'(STOP_BITS - 1)) begin
                  r_state_d = StIdle;
                  r_busy_d  = 1'b0;
                  r_done_d  = 1'b1;
               end else begin
                  r_stop_d = 1'b1;
               end
            end
            default: r_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q   <= StIdle;
         r_cnt_q     <= '0;
         r_bit_q     <= '0;
         r_shift_q   <= '0;
         r_par_en_q  <= 1'b0;
         r_par_val_q <= 1'b0;
         r_stop_q    <= 1'b0;
         r_tx_out_q  <= IDLE_LEVEL;
         r_busy_q    <= 1'b0;
         r_done_q    <= 1'b0;
         r_pbit_q    <= 1'b0;
      end else begin
         r_state_q   <= r_state_d;
         r_cnt_q     <= r_cnt_d;
         r_bit_q     <= r_bit_d;
         r_shift_q   <= r_shift_d;
         r_par_en_q  <= r_par_en_d;
         r_par_val_q <= r_par_val_d;
         r_stop_q    <= r_stop_d;
         r_tx_out_q  <= r_tx_out_d;
         r_busy_q    <= r_busy_d;
         r_done_q    <= r_done_d;
         r_pbit_q    <= r_pbit_d;
      end
   end

   assign bus.tx_ready   = (r_state_q == StIdle);
   assign bus.tx_busy    = r_busy_q;
   assign bus.tx_out     = r_tx_out_q;
   assign bus.parity_bit = r_pbit_q;
   assign bus.tx_done    = r_done_q;

endmodule

// File: tb/tb_uart_tx_parity_framer.sv
// Bench for uart_tx_parity_framer: 1- and 2-stop-bit instances against a frame-level model.
// Define UART_PARITY_INJECT_EN to also exercise parity injection.
module tb_uart_tx_parity_framer;
   import uart_pkg::*;

   localparam int CPB = 16;
`ifdef UART_PARITY_INJECT_EN
   localparam bit INJ_EN = 1'b1;
`else
   localparam bit INJ_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] s_data = '0;
   logic       s_load = 1'b0, s_pe = 1'b0, s_po = 1'b0, s_inj = 1'b0;
   int         n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   uart_tx_parity_framer_if #(.DATA_W(8)) bus1 ();
   uart_tx_parity_framer_if #(.DATA_W(8)) bus2 ();

   assign bus1.tx_data = s_data;   assign bus2.tx_data = s_data;
   assign bus1.load_data = s_load; assign bus2.load_data = s_load;
   assign bus1.parity_en = s_pe;   assign bus2.parity_en = s_pe;
   assign bus1.parity_odd = s_po;  assign bus2.parity_odd = s_po;
`ifdef UART_PARITY_INJECT_EN
   assign bus1.inject_err = s_inj; assign bus2.inject_err = s_inj;
`endif

   uart_tx_parity_framer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
      .clk (clk), .rst (rst), .bus (bus1)
   );
   uart_tx_parity_framer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
      .clk (clk), .rst (rst), .bus (bus2)
   );

   // Frame-level model: the whole frame is built as a bit list at accept time.
   typedef struct {
      bit        busy;
      bit        done;
      int        cyc;
      int        len;
      bit [15:0] bits;
      bit        pbit;
   } mdl_t;

   mdl_t m1 = '{default: 0};
   mdl_t m2 = '{default: 0};

   function automatic mdl_t mdl_step(mdl_t m, int stop_bits, bit load, bit [7:0] d, bit pe,
                                     bit po, bit inj);
      mdl_t n = m;
      bit   p;
      n.done = 1'b0;
      if (!m.busy) begin
         if (load) begin
            p = bit'($countones(d) % 2) ^ po ^ inj;
            n.busy = 1'b1;
            n.cyc  = 0;
            n.bits = '1;
            n.bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) n.bits[1+i] = d[i];
            if (pe) n.bits[9] = p;
            n.len  = 1 + 8 + int'(pe) + stop_bits;
            n.pbit = pe & p;
         end
      end else begin
         n.cyc++;
         if (n.cyc == n.len * CPB) begin
            n.busy = 1'b0;
            n.done = 1'b1;
         end
      end
      return n;
   endfunction

   function automatic bit exp_out(mdl_t m);
      return m.busy ? m.bits[m.cyc / CPB] : 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m1 <= '{default: 0};
         m2 <= '{default: 0};
      end else begin
         m1 <= mdl_step(m1, 1, s_load, s_data, s_pe, s_po, s_inj & INJ_EN);
         m2 <= mdl_step(m2, 2, s_load, s_data, s_pe, s_po, s_inj & INJ_EN);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("dut1 tx_out", 32'(bus1.tx_out), 32'(exp_out(m1)));
         chk("dut1 tx_busy", 32'(bus1.tx_busy), 32'(m1.busy));
         chk("dut1 tx_ready", 32'(bus1.tx_ready), 32'(!m1.busy));
         chk("dut1 tx_done", 32'(bus1.tx_done), 32'(m1.done));
         chk("dut1 parity_bit", 32'(bus1.parity_bit), 32'(m1.pbit));
         chk("dut2 tx_out", 32'(bus2.tx_out), 32'(exp_out(m2)));
         chk("dut2 tx_busy", 32'(bus2.tx_busy), 32'(m2.busy));
         chk("dut2 tx_ready", 32'(bus2.tx_ready), 32'(!m2.busy));
         chk("dut2 tx_done", 32'(bus2.tx_done), 32'(m2.done));
         chk("dut2 parity_bit", 32'(bus2.parity_bit), 32'(m2.pbit));
      end
   end

   task automatic start(input logic [7:0] d, input logic pe, input logic po, input logic inj);
      @(posedge clk); #1;
      s_data = d; s_pe = pe; s_po = po; s_inj = inj & INJ_EN; s_load = 1'b1;
      @(posedge clk); #1;
      s_load = 1'b0;
      s_data = 8'($urandom); s_pe = 1'($urandom); s_po = 1'($urandom);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!(bus1.tx_ready && bus2.tx_ready) && k < 1000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reached idle", 32'(bus1.tx_ready & bus2.tx_ready), 32'd1);
   endtask

   task automatic send_pchk(input logic [7:0] d, input logic pe, input logic po,
                            input logic inj, input logic exp_pb, input logic exp_slot);
      start(d, pe, po, inj);
      repeat (9 * CPB + 9) @(negedge clk);
      chk("parity slot", 32'(bus1.tx_out), 32'(exp_slot));
      chk("parity_bit", 32'(bus1.parity_bit), 32'(exp_pb));
      wait_idle();
   endtask

   initial begin
      bit exp_bits [11] = '{0, 0, 1, 1, 1, 1, 0, 1, 0, 1, 1};
      int busy_cnt;

      #1 rst = 1'b1;
      #1;
      chk("reset tx_out", 32'(bus1.tx_out), 32'd1);
      chk("reset tx_busy", 32'(bus1.tx_busy), 32'd0);
      chk("reset tx_done", 32'(bus1.tx_done), 32'd0);
      chk("reset parity_bit", 32'(bus1.parity_bit), 32'd0);
      chk("reset tx_ready", 32'(bus1.tx_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // 0x5E, even parity: hand-computed line pattern and 176-cycle frame.
      start(8'h5E, 1'b1, PARITY_EVEN, 1'b0);
      chk("model 0x5E length", 32'(m1.len), 32'd11);
      busy_cnt = 0;
      for (int i = 0; i < 11 * CPB; i++) begin
         @(negedge clk);
         if (bus1.tx_busy) busy_cnt++;
         if (i % CPB == CPB / 2) chk("0x5E frame bit", 32'(bus1.tx_out), 32'(exp_bits[i / CPB]));
      end
      @(negedge clk);
      chk("0x5E busy cycles", 32'(busy_cnt), 32'd176);
      chk("0x5E tx_done", 32'(bus1.tx_done), 32'd1);
      chk("0x5E busy fall", 32'(bus1.tx_busy), 32'd0);
      chk("0x5E parity_bit", 32'(bus1.parity_bit), 32'd1);
      wait_idle();

      send_pchk(8'h5F, 1'b1, PARITY_ODD, 1'b0, 1'b1, 1'b1);
      send_pchk(8'h5F, 1'b1, PARITY_EVEN, 1'b0, 1'b0, 1'b0);

      // No parity on the 2-stop-bit instance: 11 bit slots.
      start(8'hA5, 1'b0, PARITY_ODD, 1'b0);
      busy_cnt = 0;
      for (int i = 0; i < 400 && bus2.tx_busy; i++) begin
         @(negedge clk);
         if (bus2.tx_busy) busy_cnt++;
      end
      chk("0xA5 2-stop frame length", 32'(busy_cnt), 32'd176);
      chk("0xA5 parity_bit", 32'(bus2.parity_bit), 32'd0);
      wait_idle();

      // load_data held high while inputs keep changing: frames must abut cleanly.
      @(posedge clk); #1;
      s_load = 1'b1;
      repeat (3 * 12 * CPB + 10) begin
         @(posedge clk); #1;
         s_data = 8'($urandom); s_pe = 1'($urandom); s_po = 1'($urandom);
         s_inj = 1'($urandom) & INJ_EN;
      end
      s_load = 1'b0;
      wait_idle();

      // Random load pulses.
      repeat (4000) begin
         @(posedge clk); #1;
         s_load = ($urandom_range(7) == 0);
         s_data = 8'($urandom); s_pe = 1'($urandom); s_po = 1'($urandom);
         s_inj = 1'($urandom) & INJ_EN;
      end
      s_load = 1'b0;
      wait_idle();

      // Asynchronous reset in the middle of data bit 4.
      start(8'h5E, 1'b1, PARITY_EVEN, 1'b0);
      repeat (85) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst tx_out", 32'(bus1.tx_out), 32'd1);
      chk("async rst tx_busy", 32'(bus1.tx_busy), 32'd0);
      chk("async rst tx_ready", 32'(bus1.tx_ready), 32'd1);
      chk("async rst parity_bit", 32'(bus1.parity_bit), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      send_pchk(8'h5E, 1'b1, PARITY_EVEN, 1'b0, 1'b1, 1'b1);

`ifdef UART_PARITY_INJECT_EN
      send_pchk(8'h5E, 1'b1, PARITY_EVEN, 1'b1, 1'b0, 1'b0);
      send_pchk(8'h5E, 1'b1, PARITY_EVEN, 1'b0, 1'b1, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
